// File: rtl/pe_line_drain.sv
// rtl/pe_line_drain.sv - snapshot a PE line's accumulators and stream them out one beat at a time
//
// Purpose:
//   On cap_valid && cap_ready the packed accumulator bus of the PE line is
//   copied into a shadow register, together with the split flag. The
//   snapshot is then streamed one beat per accepted transfer. In split mode
//   each accumulator is emitted as two sign-extended half-width lanes, low
//   lane first.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_acc     packed PE results, PE k at [k*ACC_W +: ACC_W]
//   split      1 = two LANE_W lanes per accumulator (sampled at capture)
//   cap_valid  controller: in_acc is final this cycle
//   cap_ready  drain idle, capture allowed
//   out_valid  out_data holds a beat
//   out_ready  downstream accepts the beat
//   out_data   beat payload (lanes sign-extended to ACC_W)
//   out_pe     PE index of the current beat
//   out_lane   0 = low lane / full word, 1 = high lane
//   out_last   final beat of the snapshot

module pe_line_drain #(
    parameter int NUM_PE = 10,
    parameter int ACC_W  = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PE*ACC_W-1:0] in_acc,
    input  logic                    split,
    input  logic                    cap_valid,
    output logic                    cap_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [3:0]              out_pe,
    output logic                    out_lane,
    output logic                    out_last
);

    localparam int LANE_W   = ACC_W / 2;
    localparam int PE_IDX_W = $clog2(NUM_PE);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [ACC_W-1:0]    shadow [NUM_PE];
    logic                split_q;
    logic [PE_IDX_W-1:0] pe_cnt;
    logic                lane_q;

    logic cap_fire;
    logic xfer;
    logic is_last;

    logic [ACC_W-1:0]  cur_word;
    logic [LANE_W-1:0] cur_lane;

    assign cap_fire = cap_valid && (state == IDLE);
    assign xfer     = out_ready && (state == STREAM);

    // The final beat is the last PE, and in split mode only its high lane.
    assign is_last  = (pe_cnt == PE_IDX_W'(NUM_PE - 1)) && (!split_q || lane_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: cap_valid is ignored outside IDLE, so nothing queues.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cap_fire) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (xfer && is_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Snapshot and beat counters. They only move on capture or transfer,
    // which keeps every output steady while the downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PE; k++) begin
                shadow[k] <= '0;
            end
            split_q <= 1'b0;
            pe_cnt  <= '0;
            lane_q  <= 1'b0;
        end else if (cap_fire) begin
            for (int k = 0; k < NUM_PE; k++) begin
                shadow[k] <= in_acc[k*ACC_W +: ACC_W];
            end
            split_q <= split;
            pe_cnt  <= '0;
            lane_q  <= 1'b0;
        end else if (xfer) begin
            if (is_last) begin
                pe_cnt <= '0;
                lane_q <= 1'b0;
            end else if (split_q && !lane_q) begin
                lane_q <= 1'b1;
            end else begin
                lane_q <= 1'b0;
                pe_cnt <= pe_cnt + 1'b1;
            end
        end
    end

    // Beat payload comes straight from the shadow; after reset the shadow is
    // zero and the counters point at PE0 low lane, so out_data reads as zero.
    assign cur_word = shadow[pe_cnt];
    assign cur_lane = lane_q ? cur_word[ACC_W-1:LANE_W] : cur_word[LANE_W-1:0];

    assign out_data  = split_q ? {{LANE_W{cur_lane[LANE_W-1]}}, cur_lane} : cur_word;
    assign out_pe    = 4'(pe_cnt);
    assign out_lane  = lane_q;
    assign out_valid = (state == STREAM);
    assign out_last  = (state == STREAM) && is_last;
    assign cap_ready = (state == IDLE);

endmodule

// File: tb/tb_pe_line_drain.sv
// tb/tb_pe_line_drain.sv - self-checking bench for pe_line_drain
module tb_pe_line_drain;

    localparam int NUM_PE = 10;
    localparam int ACC_W  = 48;
    localparam int LANE_W = ACC_W / 2;
    localparam int W      = NUM_PE * ACC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_acc;
    logic             split;
    logic             cap_valid;
    logic             cap_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [3:0]       out_pe;
    logic             out_lane;
    logic             out_last;

    pe_line_drain #(.NUM_PE(NUM_PE), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_acc    (in_acc),
        .split     (split),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pe    (out_pe),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [3:0]       pe;
        logic             lane;
        logic             last;
    } beat_t;

    typedef struct {
        logic         split;
        logic [W-1:0] acc;
        int           mode;   // 0: ready=1, 1: ready toggles 1,0,..., 2: random
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[6];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: expand a snapshot into its expected beat sequence.
    task automatic push_expected(input logic [W-1:0] acc, input logic sp);
        beat_t            b;
        logic [LANE_W-1:0] v;
        for (int k = 0; k < NUM_PE; k++) begin
            for (int l = 0; l < (sp ? 2 : 1); l++) begin
                if (sp) begin
                    v      = acc[k*ACC_W + l*LANE_W +: LANE_W];
                    b.data = {{LANE_W{v[LANE_W-1]}}, v};
                end else begin
                    b.data = acc[k*ACC_W +: ACC_W];
                end
                b.pe   = 4'(k);
                b.lane = l[0];
                b.last = (k == NUM_PE - 1) && (l == (sp ? 1 : 0));
                sb.push_back(b);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // capture edge, with the post-capture inputs applied.
    task automatic capture(input logic [W-1:0] acc, input logic sp,
                           input logic [W-1:0] post_acc, input logic post_sp,
                           input logic post_cv);
        chk("cap_ready_before_capture", 64'(cap_ready), 64'd1);
        in_acc    = acc;
        split     = sp;
        cap_valid = 1'b1;
        push_expected(acc, sp);
        @(negedge clk);
        in_acc    = post_acc;
        split     = post_sp;
        cap_valid = post_cv;
    endtask

    // Drain beats against the scoreboard. limit < 0 runs to the end of the
    // snapshot; otherwise returns at the negedge after the limit-th transfer.
    task automatic drain(input int mode, input int limit);
        int    cyc;
        int    n;
        logic  held;
        logic  r;
        beat_t hb;
        beat_t e;
        cyc  = 0;
        n    = 0;
        held = 1'b0;
        forever begin
            if (out_valid) begin
                if (held) begin
                    chk("stall_data", 64'(out_data), 64'(hb.data));
                    chk("stall_pe",   64'(out_pe),   64'(hb.pe));
                    chk("stall_lane", 64'(out_lane), 64'(hb.lane));
                    chk("stall_last", 64'(out_last), 64'(hb.last));
                end
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                    out_ready = 1'b0;
                    break;
                end
                e = sb[0];
                chk("beat_data",      64'(out_data),  64'(e.data));
                chk("beat_pe",        64'(out_pe),    64'(e.pe));
                chk("beat_lane",      64'(out_lane),  64'(e.lane));
                chk("beat_last",      64'(out_last),  64'(e.last));
                chk("cap_ready_busy", 64'(cap_ready), 64'd0);
                case (mode)
                    0:       r = 1'b1;
                    1:       r = (cyc % 2) == 0;
                    default: r = 1'($urandom_range(0, 1));
                endcase
                out_ready = r;
                if (r) begin
                    void'(sb.pop_front());
                    n++;
                    held = 1'b0;
                end else begin
                    held    = 1'b1;
                    hb.data = out_data;
                    hb.pe   = out_pe;
                    hb.lane = out_lane;
                    hb.last = out_last;
                end
                if (r && n == limit) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    break;
                end
            end else begin
                out_ready = 1'b0;
                if (sb.size() != 0) begin
                    chk("valid_dropped_mid_stream", 64'd0, 64'd1);
                    sb.delete();
                end else begin
                    chk("cap_ready_after_last", 64'(cap_ready), 64'd1);
                end
                break;
            end
            cyc++;
            if (cyc > 200) begin
                chk("drain_timeout", 64'd1, 64'd0);
                out_ready = 1'b0;
                sb.delete();
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_cap_ready"}, 64'(cap_ready), 64'd1);
        chk({tag, "_out_data"},  64'(out_data),  64'd0);
        chk({tag, "_out_pe"},    64'(out_pe),    64'd0);
        chk({tag, "_out_lane"},  64'(out_lane),  64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
    endtask

    function automatic logic [W-1:0] rand_acc();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    logic [W-1:0] ones;
    logic [W-1:0] acc_a;
    logic [W-1:0] acc_b;

    initial begin
        ones = '1;

        // Vector table: normal ramp, split sign test, toggled backpressure,
        // extreme values, and two randomised snapshots.
        for (int i = 0; i < 6; i++) begin
            vecs[i].acc = '0;
        end
        vecs[0].split = 1'b0; vecs[0].mode = 0;
        for (int k = 0; k < NUM_PE; k++) vecs[0].acc[k*ACC_W +: ACC_W] = 48'(k * 1000);
        vecs[1].split = 1'b1; vecs[1].mode = 0;
        vecs[1].acc[3*ACC_W +: ACC_W] = {24'hFFFFFE, 24'h000005};
        vecs[2].split = 1'b0; vecs[2].mode = 1;
        for (int k = 0; k < NUM_PE; k++) vecs[2].acc[k*ACC_W +: ACC_W] = 48'(k * 1000 + 7);
        vecs[3].split = 1'b0; vecs[3].mode = 0;
        vecs[3].acc[0 +: ACC_W]     = 48'h8000_0000_0000;
        vecs[3].acc[ACC_W +: ACC_W] = 48'h7FFF_FFFF_FFFF;
        vecs[4].split = 1'b1; vecs[4].mode = 2; vecs[4].acc = rand_acc();
        vecs[5].split = 1'b1; vecs[5].mode = 1; vecs[5].acc = rand_acc();

        rst_n     = 1'b0;
        in_acc    = '0;
        split     = 1'b0;
        cap_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Split-mode sign extension spot checks on the expanded model.
        push_expected(vecs[1].acc, 1'b1);
        chk("model_beat6",  64'(sb[6].data),  64'h0000_0000_0005);
        chk("model_beat7",  64'(sb[7].data),  64'hFFFF_FFFF_FFFE);
        chk("model_last19", 64'(sb[19].last), 64'd1);
        sb.delete();

        // Table-driven snapshots; in_acc goes to all-ones after each capture.
        for (int i = 0; i < 6; i++) begin
            capture(vecs[i].acc, vecs[i].split, ones, ~vecs[i].split, 1'b0);
            drain(vecs[i].mode, -1);
        end

        // cap_valid held through a stream with a new snapshot on the bus: no
        // re-capture mid-stream, then capture on the edge after the last beat.
        acc_a = rand_acc();
        acc_b = rand_acc();
        capture(acc_a, 1'b0, acc_b, 1'b1, 1'b1);
        drain(0, -1);
        push_expected(acc_b, 1'b1);
        @(negedge clk);
        chk("recapture_after_last", 64'(out_valid), 64'd1);
        cap_valid = 1'b0;
        in_acc    = ones;
        split     = 1'b0;
        drain(1, -1);

        // Reset after beat 4 is transferred abandons the snapshot.
        capture(rand_acc(), 1'b0, ones, 1'b1, 1'b0);
        drain(0, 5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk_idle_zero("mid_reset");
        @(negedge clk);
        chk("mid_reset_no_beats", 64'(out_valid), 64'd0);
        capture(rand_acc(), 1'b1, ones, 1'b0, 1'b0);
        drain(2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
